border_frame_sched: RTL and testbench

- Frame sequencer for the 3x3 border-detection kernel. Walks one WIDTH x HEIGHT 8-bit frame in raster order.
- Issues linear read addresses to the input frame memory and shift strobes to the kernel's line-buffer/window.
- Issues write addresses, with a border-force flag, to the output frame memory, then a done pulse.
- Latches the kernel threshold at frame start. The kernel datapath itself is external.

---
 rtl/border_frame_sched.sv | 197 +++++++++++++++++++
 tb/tb_border_frame_sched.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/border_frame_sched.sv
// border_frame_sched
//
// Frame sequencer for a 3x3 border-detection kernel. It walks one
// WIDTH x HEIGHT frame in raster order. It issues read addresses to the input
// frame memory and shift strobes to the kernel window. It issues write
// addresses, each with a border-force flag, to the output frame memory. When
// the frame is complete it pulses done. The kernel datapath lives outside
// this block.
//
// Optional feature: define HOLD_STATS_EN to add the hold_cycles output.
// hold_cycles counts busy & hold cycles for the current/last frame.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   start        frame start request, accepted only in IDLE
//   thresh[7:0]  kernel threshold, sampled when start is accepted
//   hold         pause: suppresses new reads and flush writes
//   busy         high in RUN, DRAIN and DONE
//   done         one-cycle pulse at frame completion
//   thresh_q     threshold latched at frame start
//   rd_en        input memory read strobe (read latency 1)
//   rd_addr      linear read address
//   win_shift    shift rd_data into the window (rd_en delayed one cycle)
//   wr_en        output memory write strobe
//   wr_addr      linear centre address being written
//   wr_border    1 = write 0 (frame edge), 0 = write kernel result
//   hold_cycles  (HOLD_STATS_EN only) busy & hold cycle count, saturating
//
// Handshake: start is a level request; it is consumed on the first clock in
// which the sequencer is IDLE and is ignored otherwise. hold is a
// back-pressure level. It only gates work that has not yet been issued
// (reads, flush writes). Data already in flight (window shifts, pipeline
// writes) always completes.

module border_frame_sched #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int KLAT   = 1,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        thresh,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic [7:0]        thresh_q,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              win_shift,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_border
`ifdef HOLD_STATS_EN
    ,
    output logic [31:0]       hold_cycles
`endif
);

    localparam int SIZE = WIDTH * HEIGHT;

    // The first WIDTH+1 shifts only prime the window. Shift number WIDTH+1
    // is the first one that centres pixel 0.
    localparam logic [ADDR_W:0]   S_FIRST    = (ADDR_W+1)'(WIDTH + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(SIZE - 1);
    localparam logic [ADDR_W-1:0] FLUSH_FROM = ADDR_W'(SIZE - WIDTH - 1);
    localparam logic [ADDR_W-1:0] X_LAST     = ADDR_W'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] Y_LAST     = ADDR_W'(HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] r;       // next read index
    logic [ADDR_W-1:0] w;       // next write index
    logic [ADDR_W-1:0] wx, wy;  // column/row of w, tracked without division
    logic [ADDR_W:0]   s;       // window shifts seen this frame
    logic [KLAT-1:0]   dly;     // kernel latency delay line for pipeline writes

    logic start_acc;
    logic flush_wr;
    logic pipe_wr;
    logic sched;
    logic at_edge;

    assign start_acc = (state == IDLE) && start;
    assign sched     = win_shift && (s >= S_FIRST);
    assign pipe_wr   = dly[KLAT-1];
    assign at_edge   = (wx == '0) || (wx == X_LAST) || (wy == '0) || (wy == Y_LAST);

    // Pipeline and flush writes cannot coincide. Flushing starts only when w
    // has passed every pipeline address, and a pipeline write always
    // carries w < FLUSH_FROM.
    assign wr_en     = pipe_wr | flush_wr;
    assign wr_addr   = wr_en ? w : '0;
    assign wr_border = wr_en & (flush_wr | at_edge);
    assign rd_addr   = rd_en ? r : '0;

    always_comb begin
        state_nx = state;
        rd_en    = 1'b0;
        flush_wr = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                rd_en = ~hold;
                if (!hold && (r == LAST_ADDR)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (!hold && (w >= FLUSH_FROM)) begin
                    flush_wr = 1'b1;
                    if (w == LAST_ADDR) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            thresh_q  <= '0;
            r         <= '0;
            w         <= '0;
            wx        <= '0;
            wy        <= '0;
            s         <= '0;
            win_shift <= 1'b0;
            dly       <= '0;
        end else begin
            state     <= state_nx;
            win_shift <= rd_en;
            // Truncating cast drops the oldest stage: {dly[KLAT-2:0], sched}.
            dly       <= KLAT'({dly, sched});

            if (start_acc) begin
                thresh_q <= thresh;
                r        <= '0;
                w        <= '0;
                wx       <= '0;
                wy       <= '0;
                s        <= '0;
            end else begin
                if (rd_en) begin
                    r <= r + 1'b1;
                end
                if (win_shift) begin
                    s <= s + 1'b1;
                end
                if (wr_en) begin
                    w <= w + 1'b1;
                    if (wx == X_LAST) begin
                        wx <= '0;
                        wy <= wy + 1'b1;
                    end else begin
                        wx <= wx + 1'b1;
                    end
                end
            end
        end
    end

`ifdef HOLD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            hold_cycles <= '0;
        end else if (busy && hold && (hold_cycles != 32'hFFFF_FFFF)) begin
            hold_cycles <= hold_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_border_frame_sched.sv
`timescale 1ns/1ps
module tb_border_frame_sched;

    localparam int AW   = 8;
    localparam int MAXC = 256;

    logic clk = 1'b0;
    logic rst, start_a, start_b, hold;
    logic [7:0] thresh;

    always #5 clk = ~clk;

    logic a_busy, a_done, a_rd_en, a_win_shift, a_wr_en, a_wr_border;
    logic [7:0] a_thresh_q;
    logic [AW-1:0] a_rd_addr, a_wr_addr;
    logic b_busy, b_done, b_rd_en, b_win_shift, b_wr_en, b_wr_border;
    logic [7:0] b_thresh_q;
    logic [AW-1:0] b_rd_addr, b_wr_addr;
`ifdef HOLD_STATS_EN
    logic [31:0] a_hold_cycles, b_hold_cycles, o_hold_cycles;
`endif

    border_frame_sched #(.WIDTH(8), .HEIGHT(6), .KLAT(1), .ADDR_W(AW)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .thresh(thresh), .hold(hold),
        .busy(a_busy), .done(a_done), .thresh_q(a_thresh_q),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .win_shift(a_win_shift),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_border(a_wr_border)
`ifdef HOLD_STATS_EN
        , .hold_cycles(a_hold_cycles)
`endif
    );

    border_frame_sched #(.WIDTH(3), .HEIGHT(3), .KLAT(3), .ADDR_W(AW)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .thresh(thresh), .hold(hold),
        .busy(b_busy), .done(b_done), .thresh_q(b_thresh_q),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .win_shift(b_win_shift),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_border(b_wr_border)
`ifdef HOLD_STATS_EN
        , .hold_cycles(b_hold_cycles)
`endif
    );

    // Output view of whichever instance the current scenario targets.
    int sel;
    logic o_busy, o_done, o_rd_en, o_win_shift, o_wr_en, o_wr_border;
    logic [7:0] o_thresh_q;
    logic [AW-1:0] o_rd_addr, o_wr_addr;

    always_comb begin
        if (sel == 1) begin
            o_busy = b_busy; o_done = b_done; o_rd_en = b_rd_en;
            o_win_shift = b_win_shift; o_wr_en = b_wr_en; o_wr_border = b_wr_border;
            o_thresh_q = b_thresh_q; o_rd_addr = b_rd_addr; o_wr_addr = b_wr_addr;
        end else begin
            o_busy = a_busy; o_done = a_done; o_rd_en = a_rd_en;
            o_win_shift = a_win_shift; o_wr_en = a_wr_en; o_wr_border = a_wr_border;
            o_thresh_q = a_thresh_q; o_rd_addr = a_rd_addr; o_wr_addr = a_wr_addr;
        end
    end
`ifdef HOLD_STATS_EN
    assign o_hold_cycles = (sel == 1) ? b_hold_cycles : a_hold_cycles;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state: per-cycle hold pattern, expected reads,
    // and a scoreboard of expected writes {cycle[15:0], border, addr[14:0]}.
    int hold_at[MAXC];
    int exp_rd[MAXC];
    int exp_done_cyc;
    int exp_hold_cnt;
    logic [31:0] exp_q[$];
    int done_seen_cyc;
    int first_wr_cyc;

    function automatic logic [31:0] wr_rec(int c, int a, int w, int h);
        bit b;
        b = (a % w == 0) || (a % w == w - 1) || (a / w == 0) || (a / w == h - 1);
        return {16'(c), b, 15'(a)};
    endfunction

    // Reads fill every non-held cycle from cycle 1. A centre write lands
    // 1+KLAT cycles after its read. The last WIDTH+1 pixels are flushed as
    // border writes in non-held cycles once the pipeline has emptied.
    function automatic void build_model(int w, int h, int k);
        int size, j, c, last_rd, fa;
        size = w * h;
        for (int i = 0; i < MAXC; i++) exp_rd[i] = -1;
        exp_q.delete();
        j = 0;
        c = 1;
        last_rd = 0;
        while (j < size && c < MAXC - 8) begin
            if (hold_at[c] == 0) begin
                exp_rd[c] = j;
                if (j >= w + 1) exp_q.push_back(wr_rec(c + 1 + k, j - w - 1, w, h));
                last_rd = c;
                j++;
            end
            c++;
        end
        fa = size - w - 1;
        c = last_rd + 2 + k;
        while (fa < size && c < MAXC - 8) begin
            if (hold_at[c] == 0) begin
                exp_q.push_back(wr_rec(c, fa, w, h));
                fa++;
            end
            c++;
        end
        exp_done_cyc = c;
        exp_hold_cnt = 0;
        for (int i = 1; i <= exp_done_cyc; i++) exp_hold_cnt += (hold_at[i] != 0) ? 1 : 0;
    endfunction

    function automatic void clear_hold();
        for (int i = 0; i < MAXC; i++) hold_at[i] = 0;
    endfunction

    // Runs one frame on instance s (0: 8x6 KLAT=1, 1: 3x3 KLAT=3) with start
    // at cycle 0. extra_cyc >= 0 adds a second start request (thresh=200)
    // at that cycle. Every cycle is checked against the model.
    task automatic play_frame(input int s, input int extra_cyc, input logic [7:0] thr);
        int w, h, k, ncyc;
        bit exp_wr, exp_ws, exp_busy;
        logic [31:0] got, front;
        sel = s;
        w = (s == 1) ? 3 : 8;
        h = (s == 1) ? 3 : 6;
        k = (s == 1) ? 3 : 1;
        build_model(w, h, k);
        ncyc = exp_done_cyc + 4;
        done_seen_cyc = -1;
        first_wr_cyc = -1;
        for (int c = 0; c < ncyc; c++) begin
            start_a = (s == 0) && (c == 0 || c == extra_cyc);
            start_b = (s == 1) && (c == 0 || c == extra_cyc);
            if (c == 0) thresh = thr;
            else if (c == extra_cyc) thresh = 8'd200;
            else thresh = 8'($urandom_range(0, 255));
            hold = (hold_at[c] != 0);
            @(negedge clk);

            n_cmp++;
            if (o_rd_en !== (exp_rd[c] >= 0)) begin
                n_fail++;
                $display("FAIL rd_en cyc=%0d got=%b exp=%b", c, o_rd_en, exp_rd[c] >= 0);
            end
            if (exp_rd[c] >= 0) begin
                n_cmp++;
                if (o_rd_addr !== AW'(exp_rd[c])) begin
                    n_fail++;
                    $display("FAIL rd_addr cyc=%0d got=%0d exp=%0d", c, o_rd_addr, exp_rd[c]);
                end
            end
            exp_ws = (c > 0) ? (exp_rd[c > 0 ? c - 1 : 0] >= 0) : 1'b0;
            n_cmp++;
            if (o_win_shift !== exp_ws) begin
                n_fail++;
                $display("FAIL win_shift cyc=%0d got=%b exp=%b", c, o_win_shift, exp_ws);
            end
            exp_busy = (c >= 1) && (c <= exp_done_cyc);
            n_cmp++;
            if (o_busy !== exp_busy) begin
                n_fail++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", c, o_busy, exp_busy);
            end
            n_cmp++;
            if (o_done !== (c == exp_done_cyc)) begin
                n_fail++;
                $display("FAIL done cyc=%0d got=%b exp=%b", c, o_done, c == exp_done_cyc);
            end
            if (o_done === 1'b1 && done_seen_cyc < 0) done_seen_cyc = c;
            if (c >= 1) begin
                n_cmp++;
                if (o_thresh_q !== thr) begin
                    n_fail++;
                    $display("FAIL thresh_q cyc=%0d got=%0d exp=%0d", c, o_thresh_q, thr);
                end
            end

            exp_wr = (exp_q.size() > 0) && (exp_q[0][31:16] == 16'(c));
            n_cmp++;
            if (o_wr_en !== exp_wr) begin
                n_fail++;
                $display("FAIL wr_en cyc=%0d got=%b exp=%b", c, o_wr_en, exp_wr);
            end
            if (o_wr_en === 1'b1 && first_wr_cyc < 0) first_wr_cyc = c;
            if (exp_wr) begin
                front = exp_q.pop_front();
                if (o_wr_en === 1'b1) begin
                    got = {16'(c), o_wr_border, 15'(o_wr_addr)};
                    n_cmp++;
                    if (got !== front) begin
                        n_fail++;
                        $display("FAIL wr_data cyc=%0d got addr=%0d border=%b exp addr=%0d border=%b",
                                 c, o_wr_addr, o_wr_border, front[14:0], front[15]);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        start_a = 1'b0;
        start_b = 1'b0;
        hold = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL writes_pending got=%0d exp=0", exp_q.size());
        end
`ifdef HOLD_STATS_EN
        n_cmp++;
        if (o_hold_cycles !== 32'(exp_hold_cnt)) begin
            n_fail++;
            $display("FAIL hold_cycles got=%0d exp=%0d", o_hold_cycles, exp_hold_cnt);
        end
`endif
    endtask

    task automatic test_reset();
        logic [2*AW+13:0] va, vb;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; hold = 1'b0; thresh = 8'hA5;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        va = {a_busy, a_done, a_thresh_q, a_rd_en, a_rd_addr, a_win_shift, a_wr_en, a_wr_addr, a_wr_border};
        vb = {b_busy, b_done, b_thresh_q, b_rd_en, b_rd_addr, b_win_shift, b_wr_en, b_wr_addr, b_wr_border};
        n_cmp++;
        if (va !== '0) begin n_fail++; $display("FAIL reset_a got=%h exp=0", va); end
        n_cmp++;
        if (vb !== '0) begin n_fail++; $display("FAIL reset_b got=%h exp=0", vb); end
`ifdef HOLD_STATS_EN
        n_cmp++;
        if (a_hold_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_hold got=%0d exp=0", a_hold_cycles); end
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_nominal();
        clear_hold();
        play_frame(0, -1, 8'($urandom_range(0, 255)));
        n_cmp++;
        if (first_wr_cyc != 12) begin n_fail++; $display("FAIL first_write got=%0d exp=12", first_wr_cyc); end
        n_cmp++;
        if (done_seen_cyc != 60) begin n_fail++; $display("FAIL done_cycle got=%0d exp=60", done_seen_cyc); end
    endtask

    task automatic test_hold_run();
        clear_hold();
        for (int i = 5; i <= 7; i++) hold_at[i] = 1;
        play_frame(0, -1, 8'd33);
        n_cmp++;
        if (done_seen_cyc != 63) begin n_fail++; $display("FAIL hold_run_done got=%0d exp=63", done_seen_cyc); end
    endtask

    task automatic test_hold_drain();
        clear_hold();
        hold_at[52] = 1;
        hold_at[53] = 1;
        play_frame(0, -1, 8'd90);
        n_cmp++;
        if (done_seen_cyc != 62) begin n_fail++; $display("FAIL hold_drain_done got=%0d exp=62", done_seen_cyc); end
    endtask

    task automatic test_start_ignored();
        clear_hold();
        play_frame(0, 20, 8'($urandom_range(0, 199)));
    endtask

    task automatic test_reset_mid();
        logic [2*AW+13:0] v;
        clear_hold();
        sel = 0;
        hold = 1'b0;
        for (int c = 0; c <= 31; c++) begin
            start_a = (c == 0);
            thresh = 8'd77;
            rst = (c == 30);
            @(negedge clk);
            if (c == 29) begin
                n_cmp++;
                if (a_busy !== 1'b1) begin n_fail++; $display("FAIL busy_before_rst got=%b exp=1", a_busy); end
            end
            if (c == 31) begin
                v = {a_busy, a_done, a_thresh_q, a_rd_en, a_rd_addr, a_win_shift, a_wr_en, a_wr_addr, a_wr_border};
                n_cmp++;
                if (v !== '0) begin n_fail++; $display("FAIL after_rst got=%h exp=0", v); end
            end
            @(posedge clk);
            #1;
        end
        start_a = 1'b0;
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({a_win_shift, a_wr_en, a_busy} !== 3'b000) begin
                n_fail++;
                $display("FAIL quiet_after_rst cyc=%0d got=%b exp=000", c, {a_win_shift, a_wr_en, a_busy});
            end
            @(posedge clk);
            #1;
        end
        play_frame(0, -1, 8'd5);
    endtask

    task automatic test_random_hold();
        for (int f = 0; f < 3; f++) begin
            clear_hold();
            for (int i = 1; i < MAXC; i++) hold_at[i] = ($urandom_range(0, 3) == 0) ? 1 : 0;
            play_frame(0, -1, 8'($urandom_range(0, 255)));
        end
        clear_hold();
        for (int i = 1; i < MAXC; i++) hold_at[i] = ($urandom_range(0, 2) == 0) ? 1 : 0;
        play_frame(1, -1, 8'($urandom_range(0, 255)));
    endtask

    task automatic test_klat3();
        clear_hold();
        play_frame(1, -1, 8'd150);
        n_cmp++;
        if (done_seen_cyc != 18) begin n_fail++; $display("FAIL klat3_done got=%0d exp=18", done_seen_cyc); end
    endtask

    initial begin
        sel = 0;
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        hold = 1'b0;
        thresh = 8'd0;
        clear_hold();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        test_reset();
        test_nominal();
        test_hold_run();
        test_hold_drain();
        test_start_ignored();
        test_reset_mid();
        test_klat3();
        test_random_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
